// File: rtl/mdu_pkg.sv
// mdu_pkg: MDU op encodings, default latencies, FSM state and op-class helpers (MDU_MADD_EN enables madd/msub decode)
package mdu_pkg;
  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } mdu_op_e;
  localparam int MUL_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;
  localparam logic [1:0] ACC_NONE = 2'd0;
  localparam logic [1:0] ACC_ADD  = 2'd1;
  localparam logic [1:0] ACC_SUB  = 2'd2;
  typedef enum logic {IDLE, RUN} state_e;
  function automatic logic is_mul(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
`else
    return op inside {OP_MULT, OP_MULTU};
`endif
  endfunction
  function automatic logic is_div(input logic [3:0] op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction
endpackage

// File: rtl/mdu_if.sv
// mdu_if: E-stage request and HI/LO/stall response bundle between pipeline and MDU
interface mdu_if;
  logic        start;
  logic [3:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        stall_req;
  logic [31:0] HI;
  logic [31:0] LO;
  modport master (output start, MDUOp, A, B, input busy, stall_req, HI, LO);
  modport slave  (input start, MDUOp, A, B, output busy, stall_req, HI, LO);
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: IDLE/RUN sequencer with latency down-counter; flags the commit cycle
module mdu_ctrl import mdu_pkg::*; (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go_i,
  input  logic [5:0] cycles_i,
  output logic       busy_o,
  output logic       commit_o
);
  state_e     state_q;
  logic [5:0] cnt_q;
  // sequencer: load latency on go, count down in RUN, return to IDLE after the last busy cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_o  <= 1'b0;
    end else if (state_q == IDLE) begin
      if (go_i) begin
        state_q <= RUN;
        cnt_q   <= cycles_i;
        busy_o  <= 1'b1;
      end
    end else begin
      cnt_q <= cnt_q - 6'd1;
      if (cnt_q == 6'd1) begin
        state_q <= IDLE;
        busy_o  <= 1'b0;
      end
    end
  end
  assign commit_o = (state_q == RUN) && (cnt_q == 6'd1);
endmodule

// File: rtl/mdu.sv
// mdu: multiply/divide unit owning HI/LO; fixed-latency results, combinational stall request (MDU_MADD_EN adds madd/maddu/msub/msubu)
module mdu import mdu_pkg::*; #(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input logic clk,
  input logic rst_n,
  mdu_if.slave bus
);
  logic [3:0]  op;
  logic [31:0] a, b, bd;
  logic        mul_op, div_op, signed_mul, idle_start, accept, busy, commit;
  logic [31:0] hi_q, lo_q, hi_d, lo_d, tmp_hi_q, tmp_lo_q, tmp_hi_d, tmp_lo_d;
  logic [31:0] sq, sr, uq, ur;
  logic [63:0] sprod, uprod, calc, acc, res;
  logic        dz_q, dz_d;
  logic [1:0]  acc_q, acc_d, acc_op;
  assign op         = bus.MDUOp;
  assign a          = bus.A;
  assign b          = bus.B;
  assign mul_op     = is_mul(op);
  assign div_op     = is_div(op);
  assign idle_start = bus.start & ~busy;
  assign accept     = idle_start & (mul_op | div_op);
  assign bus.stall_req = busy | (bus.start & (mul_op | div_op));
  assign bus.busy   = busy;
  assign bus.HI     = hi_q;
  assign bus.LO     = lo_q;
`ifdef MDU_MADD_EN
  assign signed_mul = op inside {OP_MULT, OP_MADD, OP_MSUB};
  assign acc_op     = (op inside {OP_MADD, OP_MADDU}) ? ACC_ADD : (op inside {OP_MSUB, OP_MSUBU}) ? ACC_SUB : ACC_NONE;
`else
  assign signed_mul = op == OP_MULT;
  assign acc_op     = ACC_NONE;
`endif
  mdu_ctrl u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .go_i     (accept),
    .cycles_i (div_op ? 6'(DIV_CYCLES) : 6'(MUL_CYCLES)),
    .busy_o   (busy),
    .commit_o (commit)
  );
  // operand arithmetic; a zero divisor is replaced by 1 so the dividers never see 0 (result is discarded anyway)
  always_comb begin
    bd    = (b == 32'd0) ? 32'd1 : b;
    sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    uprod = {32'd0, a} * {32'd0, b};
    sq    = $signed(a) / $signed(bd);
    sr    = $signed(a) % $signed(bd);
    uq    = a / bd;
    ur    = a % bd;
    calc  = div_op ? ((op == OP_DIV) ? {sr, sq} : {ur, uq}) : (signed_mul ? sprod : uprod);
    {tmp_hi_d, tmp_lo_d} = accept ? calc : {tmp_hi_q, tmp_lo_q};
    dz_d  = accept ? (div_op & (b == 32'd0)) : dz_q;
    acc_d = accept ? acc_op : acc_q;
    acc   = {hi_q, lo_q};
    res   = (acc_q == ACC_ADD) ? acc + {tmp_hi_q, tmp_lo_q} : (acc_q == ACC_SUB) ? acc - {tmp_hi_q, tmp_lo_q} : {tmp_hi_q, tmp_lo_q};
    {hi_d, lo_d} = (commit & ~dz_q) ? res : {hi_q, lo_q};
    hi_d  = (idle_start && op == OP_MTHI) ? a : hi_d;
    lo_d  = (idle_start && op == OP_MTLO) ? a : lo_d;
  end
  // HI/LO and in-flight result state; reset discards any pending result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q     <= '0;
      lo_q     <= '0;
      tmp_hi_q <= '0;
      tmp_lo_q <= '0;
      dz_q     <= 1'b0;
      acc_q    <= ACC_NONE;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      tmp_hi_q <= tmp_hi_d;
      tmp_lo_q <= tmp_lo_d;
      dz_q     <= dz_d;
      acc_q    <= acc_d;
    end
  end
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed checks of mdu latency, results, stall, div-by-zero, ignore-while-busy and async reset
module tb_mdu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  mdu_if bus ();
  mdu dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic exp_stall);
    @(negedge clk);
    bus.start = 1'b1;
    bus.MDUOp = op;
    bus.A = a;
    bus.B = b;
    #1 chk("stall_req_issue", 32'(bus.stall_req), 32'(exp_stall));
    @(negedge clk);
    bus.start = 1'b0;
    bus.MDUOp = 4'd0;
  endtask
  task automatic wait_done(input string tag, input int n);
    int cyc = 0;
    while (bus.busy === 1'b1 && cyc < 50) begin
      cyc++;
      @(negedge clk);
    end
    chk(tag, 32'(cyc), 32'(n));
  endtask
  initial begin
    bus.start = 1'b0;
    bus.MDUOp = 4'd0;
    bus.A = '0;
    bus.B = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_hi", bus.HI, 32'h0);
    chk("rst_lo", bus.LO, 32'h0);
    chk("rst_stall", 32'(bus.stall_req), 32'd0);
    rst_n = 1'b1;
    issue(4'd1, 32'hFFFFFFFF, 32'd2, 1'b1);
    wait_done("mult_lat", 5);
    chk("mult_hi", bus.HI, 32'hFFFFFFFF);
    chk("mult_lo", bus.LO, 32'hFFFFFFFE);
    issue(4'd2, 32'hFFFFFFFF, 32'd2, 1'b1);
    wait_done("multu_lat", 5);
    chk("multu_hi", bus.HI, 32'h00000001);
    chk("multu_lo", bus.LO, 32'hFFFFFFFE);
    issue(4'd3, 32'hFFFFFFF9, 32'd2, 1'b1);
    wait_done("div_lat", 10);
    chk("div_lo", bus.LO, 32'hFFFFFFFD);
    chk("div_hi", bus.HI, 32'hFFFFFFFF);
    issue(4'd4, 32'd7, 32'd2, 1'b1);
    wait_done("divu_lat", 10);
    chk("divu_lo", bus.LO, 32'd3);
    chk("divu_hi", bus.HI, 32'd1);
    issue(4'd5, 32'h11, 32'd0, 1'b0);
    issue(4'd6, 32'h22, 32'd0, 1'b0);
    chk("mt_hi", bus.HI, 32'h11);
    chk("mt_lo", bus.LO, 32'h22);
    issue(4'd4, 32'd7, 32'd0, 1'b1);
    wait_done("dz_lat", 10);
    chk("dz_hi", bus.HI, 32'h11);
    chk("dz_lo", bus.LO, 32'h22);
    issue(4'd5, 32'hDEADBEEF, 32'd0, 1'b0);
    chk("mthi_busy", 32'(bus.busy), 32'd0);
    chk("mthi_hi", bus.HI, 32'hDEADBEEF);
    chk("mthi_lo", bus.LO, 32'h22);
    issue(4'd1, 32'd3, 32'd4, 1'b1);
    chk("ign_busy", 32'(bus.busy), 32'd1);
    bus.start = 1'b1;
    bus.MDUOp = 4'd1;
    bus.A = 32'd5;
    bus.B = 32'd6;
    #1 chk("ign_stall", 32'(bus.stall_req), 32'd1);
    @(negedge clk);
    bus.MDUOp = 4'd6;
    bus.A = 32'h99;
    @(negedge clk);
    bus.start = 1'b0;
    bus.MDUOp = 4'd0;
    wait_done("ign_lat", 3);
    chk("ign_hi", bus.HI, 32'h0);
    chk("ign_lo", bus.LO, 32'd12);
    issue(4'd1, 32'd7, 32'd8, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy", 32'(bus.busy), 32'd1);
    #1 rst_n = 1'b0;
    #1 chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_hi", bus.HI, 32'h0);
    chk("arst_lo", bus.LO, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    chk("post_rst_lo", bus.LO, 32'h0);
    issue(4'd0, 32'd3, 32'd3, 1'b0);
    chk("op0_busy", 32'(bus.busy), 32'd0);
    issue(4'd11, 32'd3, 32'd3, 1'b0);
    chk("op11_busy", 32'(bus.busy), 32'd0);
    chk("op11_hi", bus.HI, 32'h0);
`ifdef MDU_MADD_EN
    issue(4'd6, 32'hFFFFFFFF, 32'd0, 1'b0);
    issue(4'd8, 32'd1, 32'd1, 1'b1);
    wait_done("maddu_lat", 5);
    chk("maddu_hi", bus.HI, 32'd1);
    chk("maddu_lo", bus.LO, 32'd0);
    issue(4'd5, 32'd0, 32'd0, 1'b0);
    issue(4'd9, 32'd1, 32'd1, 1'b1);
    wait_done("msub_lat", 5);
    chk("msub_hi", bus.HI, 32'hFFFFFFFF);
    chk("msub_lo", bus.LO, 32'hFFFFFFFF);
`else
    issue(4'd7, 32'd3, 32'd3, 1'b0);
    chk("op7_busy", 32'(bus.busy), 32'd0);
    chk("op7_lo", bus.LO, 32'h0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
